amiga_bus_decode: RTL and testbench

Clocked, parametrised successor to the Amiga PAL address decoder. It decodes the high CPU address bits through a parameter-defined memory map and drives the chip-select enables for ROM, chip RAM and custom registers. It generates `_DTACK`, `_VPA` and `_BERR` from a per-access state machine with programmable wait states, chip-bus slot arbitration and a bus-error timeout. It sits between the 68000 bus interface and Agnus/ROM/expansion, replacing the C1/C3-latched PAL equations with a single-clock synchronous design.

---
 rtl/amiga_bus_pkg.sv | 39 +++
 rtl/amiga_bus_decode_if.sv | 30 +++
 rtl/amiga_wait_counter.sv | 21 ++
 rtl/amiga_bus_decode.sv | 127 ++++++++++++
 tb/tb_amiga_bus_decode.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/amiga_bus_pkg.sv
// Shared region codes, FSM states and memory-map lookup for the Amiga bus decoder.
package amiga_bus_pkg;

  localparam int ADDR_W_MAX = 8;
  localparam int MAP_W_MAX  = 3 * (2 ** ADDR_W_MAX);
  localparam int IDX_W      = $clog2(MAP_W_MAX);

  localparam logic [2:0] NONE    = 3'd0;
  localparam logic [2:0] ROM     = 3'd1;
  localparam logic [2:0] CHIP    = 3'd2;
  localparam logic [2:0] REG     = 3'd3;
  localparam logic [2:0] EXT     = 3'd4;
  localparam logic [2:0] AUTOVEC = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OVR,
    S_ARB,
    S_ACCESS,
    S_WAIT,
    S_ACK,
    S_HOLD,
    S_BERR
  } state_e;

  // Map and address arrive zero-extended to the widest supported decode.
  function automatic logic [2:0] region_of(input logic [MAP_W_MAX-1:0]  map,
                                           input logic [ADDR_W_MAX-1:0] addr,
                                           input logic                  ovl);
    logic [IDX_W-1:0] idx;
    logic [2:0]       code;
    idx  = IDX_W'(addr) * IDX_W'(3);
    code = map[idx +: 3];
    if (ovl && addr == '0) code = ROM;
    if (code > AUTOVEC)    code = NONE;
    return code;
  endfunction

endpackage

// File: rtl/amiga_bus_decode_if.sv
// 68000-side bus and chip-select signals of the decoder, all active low except A/OVL/XRDY/SLOT.
interface amiga_bus_decode_if #(
  parameter int ADDR_W = 3
);
  logic              _AS;
  logic [ADDR_W-1:0] A;
  logic              OVL;
  logic              _OVR;
  logic              XRDY;
  logic              _DBR;
  logic              SLOT;
  logic              _ROME;
  logic              _RE;
  logic              _RGAE;
  logic              _BLS;
  logic              _DAE;
  logic              _DTACK;
  logic              _VPA;
  logic              _BERR;

  modport slave (
    input  _AS, A, OVL, _OVR, XRDY, _DBR, SLOT,
    output _ROME, _RE, _RGAE, _BLS, _DAE, _DTACK, _VPA, _BERR
  );

  modport master (
    output _AS, A, OVL, _OVR, XRDY, _DBR, SLOT,
    input  _ROME, _RE, _RGAE, _BLS, _DAE, _DTACK, _VPA, _BERR
  );
endinterface

// File: rtl/amiga_wait_counter.sv
// Loadable down-counter that sticks at zero; used for wait states and bus-error timeout.
module amiga_wait_counter #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                       cnt_q <= '0;
    else if (load_i)                 cnt_q <= val_i;
    else if (dec_i && cnt_q != '0)   cnt_q <= cnt_q - W'(1);
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/amiga_bus_decode.sv
// Synchronous Amiga address decoder: map lookup, chip-bus arbitration, wait states,
// and _DTACK/_VPA/_BERR generation from a per-access FSM.
module amiga_bus_decode
  import amiga_bus_pkg::*;
#(
  parameter int                        ADDR_W      = 3,
  parameter logic [3*(2**ADDR_W)-1:0]  MAP         = 24'h2E8122,
  parameter int                        ROM_WAIT    = 2,
  parameter int                        CHIP_CYCLES = 2,
  parameter int                        TIMEOUT     = 64
) (
  input  logic               CLK,
  input  logic               RESET,
  amiga_bus_decode_if.slave  bus
);
  localparam int WAIT_MAX = (ROM_WAIT > CHIP_CYCLES) ? ROM_WAIT : CHIP_CYCLES;
  localparam int WCNT_W   = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam int TCNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_e      state_q;
  logic [2:0]  region_q;
  logic        rome_q, re_q, rgae_q, bls_q, dae_q, dtack_q, vpa_q, berr_q;

  logic [2:0]        region;
  logic              w_load, w_dec, w_zero;
  logic [WCNT_W-1:0] w_val;
  logic              t_load, t_dec, t_zero;

  assign region = region_of(MAP_W_MAX'(MAP), ADDR_W_MAX'(bus.A), bus.OVL);

  // Counters reload every idle/arbitration clock, so the value is correct on the leaving edge.
  assign w_load = (state_q == S_IDLE) || (state_q == S_ARB);
  assign w_val  = (state_q == S_IDLE) ? WCNT_W'(ROM_WAIT) : WCNT_W'(CHIP_CYCLES);
  assign w_dec  = (state_q == S_ACCESS);
  assign t_load = (state_q == S_IDLE);
  assign t_dec  = (state_q == S_ARB) || (state_q == S_ACCESS) || (state_q == S_WAIT);

  amiga_wait_counter #(.W(WCNT_W)) u_wait (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .load_i (w_load),
    .val_i  (w_val),
    .dec_i  (w_dec),
    .zero_o (w_zero)
  );

  // Loaded one short so _BERR lands exactly TIMEOUT edges after the access starts.
  amiga_wait_counter #(.W(TCNT_W)) u_timeout (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .load_i (t_load),
    .val_i  (TCNT_W'(TIMEOUT - 1)),
    .dec_i  (t_dec),
    .zero_o (t_zero)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      region_q <= NONE;
      {rome_q, re_q, rgae_q, bls_q, dtack_q, vpa_q, berr_q} <= '1;
      dae_q    <= 1'b1;
    end else begin
      dae_q <= bus._DBR;
      if (state_q == S_IDLE) begin
        if (!bus._AS) begin
          if (!bus._OVR) begin
            state_q <= S_OVR;
          end else begin
            region_q <= region;
            case (region)
              CHIP, REG: state_q <= S_ARB;
              ROM: begin
                state_q <= S_ACCESS;
                rome_q  <= 1'b0;
              end
              AUTOVEC: begin
                state_q <= S_HOLD;
                vpa_q   <= 1'b0;
              end
              default: state_q <= S_WAIT;
            endcase
          end
        end
      end else if (bus._AS) begin
        state_q <= S_IDLE;
        {rome_q, re_q, rgae_q, bls_q, dtack_q, vpa_q, berr_q} <= '1;
      end else if (t_dec && t_zero) begin
        state_q <= S_BERR;
        {rome_q, re_q, rgae_q, bls_q, dtack_q, vpa_q, berr_q} <= 7'b1111110;
      end else begin
        case (state_q)
          S_ARB: begin
            if (bus.SLOT && bus._DBR) begin
              state_q <= S_ACCESS;
              re_q    <= (region_q != CHIP);
              rgae_q  <= (region_q != REG);
              bls_q   <= 1'b0;
            end
          end
          S_ACCESS: begin
            if (w_zero && (region_q != ROM || bus.XRDY)) begin
              state_q <= S_ACK;
              dtack_q <= 1'b0;
            end
          end
          S_WAIT: begin
            if (region_q == EXT && bus.XRDY) begin
              state_q <= S_ACK;
              dtack_q <= 1'b0;
            end
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign bus._ROME  = rome_q;
  assign bus._RE    = re_q;
  assign bus._RGAE  = rgae_q;
  assign bus._BLS   = bls_q;
  assign bus._DAE   = dae_q;
  assign bus._DTACK = dtack_q;
  assign bus._VPA   = vpa_q;
  assign bus._BERR  = berr_q;
endmodule

// File: tb/tb_amiga_bus_decode.sv
// Scoreboard bench for amiga_bus_decode: stimulus queues per-edge expected outputs,
// a negedge monitor pops and compares them.
module tb_amiga_bus_decode;
  // Expected {_ROME,_RE,_RGAE,_BLS,_DTACK,_VPA,_BERR}; _DAE is inserted per step.
  localparam logic [6:0] REL      = 7'b1111111;
  localparam logic [6:0] ROME0    = 7'b0111111;
  localparam logic [6:0] ROME_ACK = 7'b0111011;
  localparam logic [6:0] CHIP_EN  = 7'b1010111;
  localparam logic [6:0] CHIP_ACK = 7'b1010011;
  localparam logic [6:0] REG_EN   = 7'b1100111;
  localparam logic [6:0] REG_ACK  = 7'b1100011;
  localparam logic [6:0] EXT_ACK  = 7'b1111011;
  localparam logic [6:0] VPA0     = 7'b1111101;
  localparam logic [6:0] BERR0    = 7'b1111110;

  logic CLK = 1'b0;
  logic RESET;

  amiga_bus_decode_if #(.ADDR_W(3)) bus ();

  amiga_bus_decode #(
    .ADDR_W(3), .MAP(24'h2E8122), .ROM_WAIT(2), .CHIP_CYCLES(2), .TIMEOUT(64)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    int         tag;
    int         tid;
    logic [7:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   ecnt   = 0;
  int   tid    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    ecnt++;
  end

  // Queue the outputs expected after the next posedge, then advance to the following negedge.
  task automatic step(input logic [6:0] e);
    exp_t x;
    x.tag = ecnt + 1;
    x.tid = tid;
    x.exp = {e[6:3], (RESET ? 1'b1 : bus._DBR), e[2:0]};
    sbq.push_back(x);
    @(negedge CLK);
  endtask

  task automatic steps(input int k, input logic [6:0] e);
    for (int i = 0; i < k; i++) step(e);
  endtask

  initial forever begin
    exp_t       x;
    logic [7:0] act;
    @(negedge CLK);
    while (sbq.size() > 0 && sbq[0].tag == ecnt) begin
      x   = sbq.pop_front();
      act = {bus._ROME, bus._RE, bus._RGAE, bus._BLS, bus._DAE, bus._DTACK, bus._VPA, bus._BERR};
      n_chk++;
      if (act !== x.exp) begin
        n_fail++;
        $display("FAIL test%0d edge%0d outs(ROME,RE,RGAE,BLS,DAE,DTACK,VPA,BERR) got %b expected %b",
                 x.tid, x.tag, act, x.exp);
      end
    end
  end

  initial begin
    RESET    = 1'b1;
    bus._AS  = 1'b1;
    bus.A    = 3'd0;
    bus.OVL  = 1'b0;
    bus._OVR = 1'b1;
    bus.XRDY = 1'b1;
    bus._DBR = 1'b1;
    bus.SLOT = 1'b0;
    @(negedge CLK);

    tid = 0; steps(2, REL); RESET = 1'b0; steps(2, REL);

    // ROM via boot overlay, immediate XRDY
    tid = 1; bus.OVL = 1'b1; bus.A = 3'd0; bus._AS = 1'b0;
    steps(3, ROME0); steps(2, ROME_ACK); bus._AS = 1'b1; step(REL); bus.OVL = 1'b0;

    // ROM from the map, XRDY late
    tid = 2; bus.A = 3'd7; bus.XRDY = 1'b0; bus._AS = 1'b0;
    steps(4, ROME0); bus.XRDY = 1'b1; steps(2, ROME_ACK); bus._AS = 1'b1; step(REL);

    // CHIP with DMA holding the bus, then DMA request after grant
    tid = 3; bus.A = 3'd0; bus._DBR = 1'b0; bus._AS = 1'b0;
    steps(3, REL); bus.SLOT = 1'b1; step(REL); bus.SLOT = 1'b0; step(REL);
    bus._DBR = 1'b1; step(REL);
    bus.SLOT = 1'b1; step(CHIP_EN);
    bus.SLOT = 1'b0; bus._DBR = 1'b0; steps(2, CHIP_EN); step(CHIP_ACK);
    bus._DBR = 1'b1; step(CHIP_ACK); bus._AS = 1'b1; step(REL);

    // REG, slot available on first arbitration clock
    tid = 4; bus.A = 3'd6; bus._AS = 1'b0; step(REL);
    bus.SLOT = 1'b1; step(REG_EN); bus.SLOT = 1'b0; steps(2, REG_EN); steps(2, REG_ACK);
    bus._AS = 1'b1; step(REL);

    // EXT, XRDY low for 10 clocks
    tid = 5; bus.A = 3'd1; bus.XRDY = 1'b0; bus._AS = 1'b0;
    steps(11, REL); bus.XRDY = 1'b1; steps(2, EXT_ACK); bus._AS = 1'b1; step(REL);

    // EXT minimum latency; OVL must not affect non-zero slots
    tid = 6; bus.A = 3'd2; bus.OVL = 1'b1; bus._AS = 1'b0;
    step(REL); step(EXT_ACK); bus._AS = 1'b1; step(REL); bus.OVL = 1'b0;

    // NONE region times out
    tid = 7; bus.A = 3'd3; bus._AS = 1'b0;
    steps(64, REL); steps(2, BERR0); bus._AS = 1'b1; step(REL);

    // Timeout wins over XRDY arriving on the same clock
    tid = 8; bus.A = 3'd1; bus.XRDY = 1'b0; bus._AS = 1'b0;
    steps(64, REL); bus.XRDY = 1'b1; steps(2, BERR0); bus._AS = 1'b1; step(REL);

    // AUTOVEC
    tid = 9; bus.A = 3'd5; bus._AS = 1'b0; steps(4, VPA0); bus._AS = 1'b1; step(REL);

    // External override suppresses ROM and AUTOVEC
    tid = 10; bus._OVR = 1'b0; bus.A = 3'd7; bus._AS = 1'b0; steps(6, REL);
    bus._AS = 1'b1; step(REL);
    bus.A = 3'd5; bus._AS = 1'b0; steps(3, REL); bus._AS = 1'b1; step(REL); bus._OVR = 1'b1;

    // Abort during ARB, then a normal REG access
    tid = 11; bus.A = 3'd0; bus._DBR = 1'b0; bus._AS = 1'b0; steps(3, REL);
    bus._AS = 1'b1; bus._DBR = 1'b1; step(REL);
    bus.A = 3'd6; bus.SLOT = 1'b1; bus._AS = 1'b0; step(REL); step(REG_EN);
    bus.SLOT = 1'b0; steps(2, REG_EN); step(REG_ACK); bus._AS = 1'b1; step(REL);

    // Reset during ROM ACCESS, then a normal ROM access
    tid = 12; bus.A = 3'd7; bus._AS = 1'b0; steps(2, ROME0);
    RESET = 1'b1; bus._DBR = 1'b0; step(REL);
    RESET = 1'b0; bus._DBR = 1'b1; bus._AS = 1'b1; step(REL);
    bus._AS = 1'b0; steps(3, ROME0); step(ROME_ACK); bus._AS = 1'b1; step(REL);

    steps(2, REL);
    #1;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain pending %0d expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
